// File: rtl/ctrl_pkg.sv
// Shared control-word definitions for the decoder and the pipeline hazard unit:
// field positions, register index type and forwarding-select encoding.
package ctrl_pkg;

  localparam int unsigned CW_WR_REGFILE = 22;
  localparam int unsigned CW_RS_HI      = 21;
  localparam int unsigned CW_RS_LO      = 17;
  localparam int unsigned CW_RT_HI      = 16;
  localparam int unsigned CW_RT_LO      = 12;
  localparam int unsigned CW_RD_HI      = 11;
  localparam int unsigned CW_RD_LO      = 7;
  localparam int unsigned CW_CS         = 2;
  localparam int unsigned CW_WR         = 1;
  localparam int unsigned CW_MUX_REG    = 0;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [FWD_W-1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// Operand-forwarding comparator for one EX source register; MEM beats WB.
module fwd_select
  import ctrl_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic [REG_W-1:0] src_reg_i,
  input  logic             mem_writer_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             wb_writer_i,
  input  logic [REG_W-1:0] wb_rd_i,
  output logic [FWD_W-1:0] fwd_c_o
);

  always_comb begin
    fwd_c_o = FWD_REG;
    if (ex_valid_i) begin
      if (mem_writer_i && (mem_rd_i == src_reg_i)) begin
        fwd_c_o = FWD_MEM;
      end else if (wb_writer_i && (wb_rd_i == src_reg_i)) begin
        fwd_c_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// EX/MEM/WB control-word pipeline with load-use stall and forwarding selects.
// Optional stall counter enabled by defining CTRL_PIPE_STALL_CNT_EN.
module ctrl_pipe_hazard
  import ctrl_pkg::*;
#(
  parameter int unsigned CW_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW_W-1:0]  ctrl_in,
  input  logic             ctrl_valid,
  output logic             ctrl_ready,
  input  logic             pipe_en,
  output logic [CW_W-1:0]  ex_ctrl,
  output logic             ex_valid,
  output logic [CW_W-1:0]  mem_ctrl,
  output logic             mem_valid,
  output logic [CW_W-1:0]  wb_ctrl,
  output logic             wb_valid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CW_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CW_W-1:0] mem_ctrl_q, mem_ctrl_d;
  logic [CW_W-1:0] wb_ctrl_q, wb_ctrl_d;
  logic            ex_valid_q, ex_valid_d;
  logic            mem_valid_q, mem_valid_d;
  logic            wb_valid_q, wb_valid_d;

  reg_idx_t in_rs, in_rt;
  reg_idx_t ex_rs, ex_rt, ex_rd;
  reg_idx_t mem_rd, wb_rd;
  logic     ex_load_c, mem_writer_c, wb_writer_c, hazard_c;

  assign in_rs  = ctrl_in[CW_RS_HI:CW_RS_LO];
  assign in_rt  = ctrl_in[CW_RT_HI:CW_RT_LO];
  assign ex_rs  = ex_ctrl_q[CW_RS_HI:CW_RS_LO];
  assign ex_rt  = ex_ctrl_q[CW_RT_HI:CW_RT_LO];
  assign ex_rd  = ex_ctrl_q[CW_RD_HI:CW_RD_LO];
  assign mem_rd = mem_ctrl_q[CW_RD_HI:CW_RD_LO];
  assign wb_rd  = wb_ctrl_q[CW_RD_HI:CW_RD_LO];

  // r0 is hard-wired, so a write to it is never a forwarding source
  assign mem_writer_c = mem_valid_q && mem_ctrl_q[CW_WR_REGFILE] && (mem_rd != '0);
  assign wb_writer_c  = wb_valid_q && wb_ctrl_q[CW_WR_REGFILE] && (wb_rd != '0);

  assign ex_load_c = ex_valid_q && ex_ctrl_q[CW_CS] && !ex_ctrl_q[CW_WR]
                     && ex_ctrl_q[CW_WR_REGFILE];
  // rt is checked for every consumer since stores read it as data
  assign hazard_c  = ex_load_c && ctrl_valid && (ex_rd != '0)
                     && ((ex_rd == in_rs) || (ex_rd == in_rt));

  assign ctrl_ready = pipe_en && !hazard_c;

  always_comb begin
    ex_ctrl_d   = ex_ctrl_q;
    ex_valid_d  = ex_valid_q;
    mem_ctrl_d  = mem_ctrl_q;
    mem_valid_d = mem_valid_q;
    wb_ctrl_d   = wb_ctrl_q;
    wb_valid_d  = wb_valid_q;
    if (pipe_en) begin
      wb_ctrl_d   = mem_ctrl_q;
      wb_valid_d  = mem_valid_q;
      mem_ctrl_d  = ex_ctrl_q;
      mem_valid_d = ex_valid_q;
      if (hazard_c) begin
        ex_ctrl_d  = '0;
        ex_valid_d = 1'b0;
      end else begin
        ex_ctrl_d  = ctrl_in;
        ex_valid_d = ctrl_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q   <= '0;
      ex_valid_q  <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_valid_q <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_valid_q  <= ex_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_valid_q <= mem_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  assign ex_ctrl   = ex_ctrl_q;
  assign ex_valid  = ex_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_valid = mem_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_valid  = wb_valid_q;

  fwd_select u_fwd_a (
    .ex_valid_i   (ex_valid_q),
    .src_reg_i    (ex_rs),
    .mem_writer_i (mem_writer_c),
    .mem_rd_i     (mem_rd),
    .wb_writer_i  (wb_writer_c),
    .wb_rd_i      (wb_rd),
    .fwd_c_o      (fwd_a)
  );

  fwd_select u_fwd_b (
    .ex_valid_i   (ex_valid_q),
    .src_reg_i    (ex_rt),
    .mem_writer_i (mem_writer_c),
    .mem_rd_i     (mem_rd),
    .wb_writer_i  (wb_writer_c),
    .wb_rd_i      (wb_rd),
    .fwd_c_o      (fwd_b)
  );

`ifdef CTRL_PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of bubbles inserted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pipe_en && hazard_c && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: stage-array reference model checked every cycle,
// plus directed hazard/forwarding scenarios with literal expectations.
module tb_ctrl_pipe_hazard;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_in;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        pipe_en;
  logic [31:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic        ex_valid, mem_valid, wb_valid;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

`ifdef CTRL_PIPE_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  ctrl_pipe_hazard dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_in    (ctrl_in),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .pipe_en    (pipe_en),
    .ex_ctrl    (ex_ctrl),
    .ex_valid   (ex_valid),
    .mem_ctrl   (mem_ctrl),
    .mem_valid  (mem_valid),
    .wb_ctrl    (wb_ctrl),
    .wb_valid   (wb_valid),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB
  logic [31:0] mc [3];
  logic        mv [3];
  logic [15:0] m_cnt;

  function automatic logic [31:0] mk(input logic wrf, input logic cs, input logic wr,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {9'h0, wrf, rs, rt, rd, 4'h0, cs, wr, 1'b0};
  endfunction

  function automatic logic m_hazard();
    logic [31:0] e;
    logic [4:0]  rd;
    e  = mc[0];
    rd = e[11:7];
    if (!(mv[0] && e[2] && !e[1] && e[22])) return 1'b0;
    if (!ctrl_valid || rd == 5'd0) return 1'b0;
    return (rd == ctrl_in[21:17]) || (rd == ctrl_in[16:12]);
  endfunction

  // The stage distance from EX is itself the select code (1 = MEM, 2 = WB)
  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    logic [31:0] w;
    if (!mv[0]) return 2'b00;
    for (int s = 1; s <= 2; s++) begin
      w = mc[s];
      if (mv[s] && w[22] && w[11:7] != 5'd0 && w[11:7] == src) return 2'(s);
    end
    return 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mc[i] <= 32'h0;
        mv[i] <= 1'b0;
      end
      m_cnt <= 16'h0;
    end else if (pipe_en) begin
      if (CNT_ON && m_hazard() && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      mc[2] <= mc[1];
      mv[2] <= mv[1];
      mc[1] <= mc[0];
      mv[1] <= mv[0];
      mc[0] <= m_hazard() ? 32'h0 : ctrl_in;
      mv[0] <= m_hazard() ? 1'b0 : ctrl_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_model();
    logic [31:0] e;
    e = mc[0];
    chk("m.ex_ctrl",   ex_ctrl,   mc[0]);
    chk("m.ex_valid",  32'(ex_valid),  32'(mv[0]));
    chk("m.mem_ctrl",  mem_ctrl,  mc[1]);
    chk("m.mem_valid", 32'(mem_valid), 32'(mv[1]));
    chk("m.wb_ctrl",   wb_ctrl,   mc[2]);
    chk("m.wb_valid",  32'(wb_valid),  32'(mv[2]));
    chk("m.ctrl_ready", 32'(ctrl_ready), 32'(pipe_en && !m_hazard()));
    chk("m.fwd_a", 32'(fwd_a), 32'(exp_fwd(e[21:17])));
    chk("m.fwd_b", 32'(fwd_b), 32'(exp_fwd(e[16:12])));
    chk("m.stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  // Compare against the model with inputs settled, then advance one clock
  task automatic tick();
    #1;
    cmp_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic en);
    ctrl_in    = w;
    ctrl_valid = v;
    pipe_en    = en;
  endtask

  task automatic drain();
    drive(32'h0, 1'b0, 1'b1);
    repeat (3) tick();
  endtask

  logic [31:0] add3, sub4, add3b, use3, ld7, add8, st7, ld0, use0, i10, i11, ld7b;
  logic [15:0] cnt_exp;

  initial begin
    add3  = mk(1, 0, 0, 5'd1, 5'd2, 5'd3) | 32'hA500_0000;
    sub4  = mk(1, 0, 0, 5'd3, 5'd5, 5'd4);
    add3b = mk(1, 0, 0, 5'd6, 5'd6, 5'd3);
    use3  = mk(1, 0, 0, 5'd3, 5'd3, 5'd9);
    ld7   = mk(1, 1, 0, 5'd1, 5'd0, 5'd7);
    add8  = mk(1, 0, 0, 5'd7, 5'd1, 5'd8);
    st7   = mk(0, 1, 1, 5'd2, 5'd7, 5'd0);
    ld0   = mk(1, 1, 0, 5'd1, 5'd0, 5'd0);
    use0  = mk(1, 0, 0, 5'd0, 5'd0, 5'd9);
    i10   = mk(1, 0, 0, 5'd1, 5'd2, 5'd10);
    i11   = mk(1, 0, 0, 5'd1, 5'd2, 5'd11);
    ld7b  = mk(1, 1, 0, 5'd11, 5'd0, 5'd7);

    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.ex_valid", 32'(ex_valid), 32'd0);
    chk("rst.ctrl_ready", 32'(ctrl_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back producer/consumer: forward from MEM
    drive(add3, 1'b1, 1'b1); tick();
    drive(sub4, 1'b1, 1'b1); tick();
    drive(32'h0, 1'b0, 1'b1); #1;
    chk("b2b.mem_ctrl", mem_ctrl, add3);
    chk("b2b.fwd_a", 32'(fwd_a), 32'd1);
    chk("b2b.fwd_b", 32'(fwd_b), 32'd0);
    drain();

    // One no-op between: forward from WB
    drive(add3, 1'b1, 1'b1); tick();
    drive(32'h0, 1'b0, 1'b1); tick();
    drive(sub4, 1'b1, 1'b1); tick();
    drive(32'h0, 1'b0, 1'b1); #1;
    chk("gap.fwd_a", 32'(fwd_a), 32'd2);
    drain();

    // Two writers of r3 in flight: the newer (MEM) one wins
    drive(add3, 1'b1, 1'b1); tick();
    drive(add3b, 1'b1, 1'b1); tick();
    drive(use3, 1'b1, 1'b1); tick();
    drive(32'h0, 1'b0, 1'b1); #1;
    chk("prio.fwd_a", 32'(fwd_a), 32'd1);
    chk("prio.fwd_b", 32'(fwd_b), 32'd1);
    drain();

    // Load-use on rs: one bubble; consumer reaches EX as the load reaches WB
    drive(ld7, 1'b1, 1'b1); tick();
    drive(add8, 1'b1, 1'b1); #1;
    chk("lu.ready_stall", 32'(ctrl_ready), 32'd0);
    tick();
    #1;
    chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu.bubble_ctrl", ex_ctrl, 32'h0);
    chk("lu.ready_after", 32'(ctrl_ready), 32'd1);
    tick();
    drive(32'h0, 1'b0, 1'b1); #1;
    chk("lu.ex_ctrl", ex_ctrl, add8);
    chk("lu.fwd_a", 32'(fwd_a), 32'd2);
    cnt_exp = CNT_ON ? 16'd1 : 16'd0;
    chk("lu.stall_cnt", 32'(stall_cnt), 32'(cnt_exp));
    drain();

    // Load followed by a store reading the loaded register as rt
    drive(ld7, 1'b1, 1'b1); tick();
    drive(st7, 1'b1, 1'b1); #1;
    chk("st.ready_stall", 32'(ctrl_ready), 32'd0);
    tick();
    tick();
    drive(32'h0, 1'b0, 1'b1); #1;
    chk("st.ex_ctrl", ex_ctrl, st7);
    chk("st.fwd_b", 32'(fwd_b), 32'd2);
    chk("st.fwd_a", 32'(fwd_a), 32'd0);
    drain();

    // Writer of r0 never stalls or forwards
    drive(ld0, 1'b1, 1'b1); tick();
    drive(use0, 1'b1, 1'b1); #1;
    chk("r0.ready", 32'(ctrl_ready), 32'd1);
    tick();
    drive(32'h0, 1'b0, 1'b1); #1;
    chk("r0.ex_ctrl", ex_ctrl, use0);
    chk("r0.fwd_a", 32'(fwd_a), 32'd0);
    chk("r0.fwd_b", 32'(fwd_b), 32'd0);
    drain();

    // Freeze with a full pipe and a pending hazard
    drive(i10, 1'b1, 1'b1); tick();
    drive(i11, 1'b1, 1'b1); tick();
    drive(ld7b, 1'b1, 1'b1); tick();
    drive(add8, 1'b1, 1'b0);
    cnt_exp = CNT_ON ? 16'd2 : 16'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("frz.ready", 32'(ctrl_ready), 32'd0);
      chk("frz.ex_ctrl", ex_ctrl, ld7b);
      chk("frz.mem_ctrl", mem_ctrl, i11);
      chk("frz.wb_ctrl", wb_ctrl, i10);
      chk("frz.fwd_a", 32'(fwd_a), 32'd1);
      chk("frz.stall_cnt", 32'(stall_cnt), 32'(cnt_exp));
      tick();
    end

    // Asynchronous reset with every stage valid
    drive(add8, 1'b1, 1'b1); #1;
    chk("ar.pre_wb_valid", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar.ex_valid", 32'(ex_valid), 32'd0);
    chk("ar.mem_valid", 32'(mem_valid), 32'd0);
    chk("ar.wb_valid", 32'(wb_valid), 32'd0);
    chk("ar.ex_ctrl", ex_ctrl, 32'h0);
    chk("ar.fwd_a", 32'(fwd_a), 32'd0);
    chk("ar.fwd_b", 32'(fwd_b), 32'd0);
    chk("ar.ctrl_ready", 32'(ctrl_ready), 32'd1);
    chk("ar.stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    drive(add8, 1'b1, 1'b1); tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
